// File: rtl/seg7_scan_decoder.sv
// Rebuilds four BCD digits from a multiplexed seven-segment bus by sampling segments and anodes.
// Reports illegal patterns per digit, completed frames and a stale-bus timeout.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] bcd_out,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        frame_strobe,
  output logic        timeout
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  logic [6:0]    seg_s1, seg_s2;
  logic [3:0]    an_s1, an_s2;
  logic [10:0]   sample, prev_sample;
  state_t        state, state_nxt;
  logic [SW-1:0] stab_cnt, stab_cnt_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    seen;
  logic          dig_sel;
  logic [1:0]    dig_idx;
  logic          pat_legal;
  logic [3:0]    pat_val;
  logic          capture;
  logic [3:0]    seen_upd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1      <= '0;
      seg_s2      <= '0;
      an_s1       <= '0;
      an_s2       <= '0;
      prev_sample <= '0;
    end else begin
      seg_s1      <= seg_in;
      seg_s2      <= seg_s1;
      an_s1       <= an_in;
      an_s2       <= an_s1;
      prev_sample <= sample;
    end
  end

  assign sample = {an_s2, seg_s2};

  // Blank (no anode low) and ghosting (several low) both mean no digit.
  always_comb begin
    dig_sel = 1'b1;
    dig_idx = 2'd0;
    case (an_s2)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: dig_sel = 1'b0;
    endcase
  end

  always_comb begin
    pat_legal = 1'b1;
    pat_val   = 4'hF;
    case (seg_s2)
      7'b1111110: pat_val = 4'd0;
      7'b0110000: pat_val = 4'd1;
      7'b1101101: pat_val = 4'd2;
      7'b1111001: pat_val = 4'd3;
      7'b0110011: pat_val = 4'd4;
      7'b1011011: pat_val = 4'd5;
      7'b1011111: pat_val = 4'd6;
      7'b1110000: pat_val = 4'd7;
      7'b1111111: pat_val = 4'd8;
      7'b1111011: pat_val = 4'd9;
      default:    pat_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      stab_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stab_cnt <= stab_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stab_cnt_nxt = stab_cnt;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (dig_sel) begin
          state_nxt    = SETTLE;
          stab_cnt_nxt = SW'(1);
        end
      end
      SETTLE: begin
        if (sample == prev_sample) begin
          if (stab_cnt != STAB_MAX) stab_cnt_nxt = stab_cnt + 1'b1;
          if (stab_cnt == STAB_LAST) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          stab_cnt_nxt = SW'(1);
          state_nxt    = dig_sel ? SETTLE : IDLE;
        end
      end
      HOLD: begin
        if (sample != prev_sample) begin
          stab_cnt_nxt = SW'(1);
          state_nxt    = dig_sel ? SETTLE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign seen_upd = seen | (4'b0001 << dig_idx);

  // A capture in the same cycle the timeout would fire takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_out      <= '0;
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      frame_strobe <= 1'b0;
      timeout      <= 1'b0;
      tmo_cnt      <= '0;
      seen         <= '0;
    end else begin
      frame_strobe <= 1'b0;
      if (capture) begin
        bcd_out[{dig_idx, 2'b00} +: 4] <= pat_legal ? pat_val : 4'hF;
        digit_err[dig_idx]             <= ~pat_legal;
        tmo_cnt                        <= '0;
        timeout                        <= 1'b0;
        if (seen_upd == 4'hF) begin
          frame_strobe <= 1'b1;
          frame_valid  <= 1'b1;
          seen         <= '0;
        end else begin
          seen <= seen_upd;
        end
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == TMO_LAST) begin
          timeout     <= 1'b1;
          frame_valid <= 1'b0;
          seen        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed table, multi-cycle corner sequences, then random scan
// traffic compared every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int S = 16;
  localparam int T = 300;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        frame_valid, frame_strobe, timeout;

  seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .digit_err(digit_err), .frame_valid(frame_valid),
    .frame_strobe(frame_strobe), .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                           7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  localparam logic [6:0] DASH = 7'b0000001;

  int total = 0;
  int bad = 0;
  int strobes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a digit is captured when a single-digit sample has been seen exactly S times in a row.
  logic [10:0] m_s1, m_s2, m_last;
  int          m_run, m_tcnt;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_err, m_seen;
  logic        m_fv, m_strobe, m_tmo;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  function automatic int active_digit(input logic [3:0] a);
    int n = 0, idx = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_last = '0; m_run = 0; m_tcnt = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    m_err = '0; m_seen = '0; m_fv = 0; m_strobe = 0; m_tmo = 0;
  endtask

  task automatic model_edge();
    int d, v;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_s2 == m_last) m_run++; else m_run = 1;
    m_last   = m_s2;
    m_strobe = 0;
    d = active_digit(m_s2[10:7]);
    if (d >= 0 && m_run == S) begin
      v = decode(m_s2[6:0]);
      m_dig[d] = (v < 0) ? 4'hF : 4'(v);
      m_err[d] = (v < 0);
      m_seen[d] = 1'b1;
      m_tcnt = 0;
      m_tmo = 0;
      if (m_seen == 4'hF) begin
        m_strobe = 1; m_fv = 1; m_seen = '0;
      end
    end else if (m_tcnt < T) begin
      m_tcnt++;
      if (m_tcnt == T) begin
        m_tmo = 1; m_fv = 0; m_seen = '0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {an_in, seg_in};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {9'd0, bcd_out, digit_err, frame_valid, frame_strobe, timeout},
        {9'd0, m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_err, m_fv, m_strobe, m_tmo});
    if (frame_strobe) strobes++;
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in = a; seg_in = s;
    for (int k = 0; k < n; k++) step();
  endtask

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          dwell;
    logic [15:0] bcd;
    logic [3:0]  err;
    logic        fv;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{4'b0111, pat[1], 50,  16'h1000, 4'b0000, 1'b0};
    vt[1]  = '{4'b1011, pat[2], 50,  16'h1200, 4'b0000, 1'b0};
    vt[2]  = '{4'b1101, pat[3], 50,  16'h1230, 4'b0000, 1'b0};
    vt[3]  = '{4'b1110, pat[4], 50,  16'h1234, 4'b0000, 1'b1};
    vt[4]  = '{4'b1011, DASH,   50,  16'h1F34, 4'b0100, 1'b1};
    vt[5]  = '{4'b1011, pat[7], 50,  16'h1734, 4'b0000, 1'b1};
    vt[6]  = '{4'b1110, pat[5], S-1, 16'h1734, 4'b0000, 1'b1};
    vt[7]  = '{4'b1111, 7'd0,   20,  16'h1734, 4'b0000, 1'b1};
    vt[8]  = '{4'b1110, pat[5], S,   16'h1734, 4'b0000, 1'b1};
    vt[9]  = '{4'b1111, 7'd0,   20,  16'h1735, 4'b0000, 1'b1};
    vt[10] = '{4'b1100, pat[8], 100, 16'h1735, 4'b0000, 1'b1};
    vt[11] = '{4'b1111, 7'd0,   100, 16'h1735, 4'b0000, 1'b1};

    model_reset();
    for (int k = 0; k < 3; k++) step();
    chk("reset_outputs", {9'd0, bcd_out, digit_err, frame_valid, frame_strobe, timeout}, 32'd0);
    reset_n = 1'b1;
    drive(4'hF, 7'd0, 4);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].an, vt[i].seg, vt[i].dwell);
      chk($sformatf("vec%0d_bcd", i), 32'(bcd_out), 32'(vt[i].bcd));
      chk($sformatf("vec%0d_err", i), 32'(digit_err), 32'(vt[i].err));
      chk($sformatf("vec%0d_fv", i), 32'(frame_valid), 32'(vt[i].fv));
      if (i == 3) chk("one_frame_strobe", strobes, 1);
    end

    // Input edge to bcd_out update takes 2 + S clock edges.
    an_in = 4'b1101; seg_in = pat[6];
    for (int k = 1; k <= S + 2; k++) begin
      step();
      if (k == S + 1) chk("latency_before", 32'(bcd_out), 32'h1735);
      if (k == S + 2) chk("latency_at", 32'(bcd_out), 32'h1765);
    end

    an_in = 4'hF; seg_in = '0;
    for (int k = 1; k <= T; k++) begin
      step();
      if (k == T - 1) chk("timeout_early", 32'(timeout), 32'd0);
    end
    chk("timeout_set", 32'(timeout), 32'd1);
    chk("timeout_fv", 32'(frame_valid), 32'd0);
    chk("timeout_bcd_held", 32'(bcd_out), 32'h1765);

    an_in = 4'b0111; seg_in = pat[9];
    for (int k = 1; k <= S + 2; k++) begin
      step();
      if (k == S + 1) chk("resume_still_timeout", 32'(timeout), 32'd1);
    end
    chk("resume_timeout_clear", 32'(timeout), 32'd0);
    chk("resume_bcd", 32'(bcd_out), 32'h9765);
    chk("resume_fv", 32'(frame_valid), 32'd0);

    drive(4'b1110, pat[0], S + 2);
    drive(4'b1011, pat[2], 5);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", {9'd0, bcd_out, digit_err, frame_valid, frame_strobe, timeout}, 32'd0);
    for (int k = 0; k < 3; k++) step();
    reset_n = 1'b1;
    for (int k = 1; k <= S + 2; k++) begin
      step();
      if (k == S + 1) chk("post_reset_no_cap", 32'(bcd_out), 32'h0000);
    end
    chk("post_reset_cap", 32'(bcd_out), 32'h0200);
    chk("post_reset_fv", 32'(frame_valid), 32'd0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] a;
      logic [6:0] s;
      int n;
      if (i % 20 == 19) begin
        a = 4'hF; s = '0; n = T + 50;
      end else begin
        a = ($urandom_range(0, 3) != 0) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
        s = ($urandom_range(0, 4) != 0) ? pat[$urandom_range(0, 9)] : 7'($urandom);
        n = $urandom_range(1, 40);
      end
      drive(a, s, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
